// File: rtl/muldiv_if.sv
// Request/response bundle between the register-file read/write ports and
// the iterative multiply/divide unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [4:0]       dest_reg;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [4:0]       result_reg;

    modport master (
        output start, op, operand_a, operand_b, dest_reg,
        input  busy, done, result, result_reg
    );

    modport slave (
        input  start, op, operand_a, operand_b, dest_reg,
        output busy, done, result, result_reg
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide: one iteration per cycle for WIDTH
// cycles, shift-add for MUL/MULHU and restoring division for DIVU/REMU.
// One pair of registers (hi/lo) is shared by both algorithms:
//   multiply: {hi[WIDTH-1:0], lo} is the product, lo starts as the multiplier
//   divide:   hi is the partial remainder, lo shifts the dividend out and the
//             quotient in
// op[1] selects divide, op[0] selects the hi half as the result.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset_n,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic [1:0] op;
        logic [4:0] dst;
    } req_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    req_t             req_q;
    logic [WIDTH-1:0] opnd_q;            // multiplicand (mul) or divisor (div)
    logic [WIDTH:0]   hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] result_q;
    logic [4:0]       result_reg_q;

    logic             accept;
    logic             load_res;

    // single-iteration datapath
    logic [WIDTH:0]   mul_sum, mul_acc;
    logic [WIDTH:0]   div_shift, div_diff;
    logic             div_ge;
    logic [WIDTH:0]   iter_hi;
    logic [WIDTH-1:0] iter_lo;

    // One iteration of shift-add or restoring division, from the current regs
    always_comb begin
        // hi_q[WIDTH] is always 0 in multiply mode, so the full-width add is safe
        mul_sum   = hi_q + {1'b0, opnd_q};
        mul_acc   = lo_q[0] ? mul_sum : hi_q;
        // 33-bit working remainder: shift in the next dividend bit, then trial-subtract
        div_shift = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        if (req_q.op[1]) begin
            iter_hi = div_ge ? div_diff : div_shift;
            iter_lo = {lo_q[WIDTH-2:0], div_ge};
        end else begin
            iter_hi = {1'b0, mul_acc[WIDTH:1]};
            iter_lo = {mul_acc[0], lo_q[WIDTH-1:1]};
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state, counter and datapath next values
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        accept   = 1'b0;
        load_res = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                    cnt_d   = '0;
                    hi_d    = '0;
                    lo_d    = bus.op[1] ? bus.operand_a : bus.operand_b;
                end
            end
            RUN: begin
                cnt_d = cnt_q + CW'(1);
                hi_d  = iter_hi;
                lo_d  = iter_lo;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = DONE;
                    load_res = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath, counter and captured request; operands are frozen at accept
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            req_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            if (accept) begin
                opnd_q    <= bus.op[1] ? bus.operand_b : bus.operand_a;
                req_q.op  <= bus.op;
                req_q.dst <= bus.dest_reg;
            end
        end
    end

    // Result registers load on the last iteration so they are valid during DONE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_q     <= '0;
            result_reg_q <= '0;
        end else if (load_res) begin
            result_q     <= req_q.op[0] ? iter_hi[WIDTH-1:0] : iter_lo;
            result_reg_q <= req_q.dst;
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == DONE);
    assign bus.result     = result_q;
    assign bus.result_reg = result_reg_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, occupancy, arithmetic corner
// cases, start isolation while busy, and asynchronous reset mid-operation.
module tb_muldiv_unit;
    logic clk;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the unit idle; runs one op to completion.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] d, input logic [31:0] exp);
        int k;
        int bcnt;
        bit seen;
        bus.op = o; bus.operand_a = a; bus.operand_b = b; bus.dest_reg = d;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.operand_a = $urandom;
        bus.operand_b = $urandom;
        bus.dest_reg  = 5'd31;
        k = 0;
        bcnt = bus.busy ? 1 : 0;
        seen = 0;
        while (!seen && k < 100) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (bus.busy) bcnt++;
            if (bus.done) seen = 1;
        end
        chk($sformatf("%s latency", tag), 64'(k), 64'd32);
        chk($sformatf("%s result", tag), 64'(bus.result), 64'(exp));
        chk($sformatf("%s result_reg", tag), 64'(bus.result_reg), 64'(d));
        chk($sformatf("%s busy_cycles", tag), 64'(bcnt), 64'd33);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("%s idle_busy", tag), 64'(bus.busy), 64'd0);
        chk($sformatf("%s idle_done", tag), 64'(bus.done), 64'd0);
        chk($sformatf("%s result_hold", tag), 64'(bus.result), 64'(exp));
    endtask

    initial begin
        int ndone;
        int done_k;
        logic [31:0] done_res;

        reset_n = 1'b0;
        bus.start = 1'b0; bus.op = 2'b00;
        bus.operand_a = '0; bus.operand_b = '0; bus.dest_reg = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset done", 64'(bus.done), 64'd0);
        chk("reset result", 64'(bus.result), 64'd0);
        chk("reset result_reg", 64'(bus.result_reg), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_op("mul7x6",   2'b00, 32'd7,        32'd6,        5'd5,  32'h0000002A);
        run_op("mulFF",    2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'h00000001);
        run_op("mulhuFF",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE);
        run_op("divu100",  2'b10, 32'd100,      32'd7,        5'd3,  32'h0000000E);
        run_op("remu100",  2'b11, 32'd100,      32'd7,        5'd4,  32'h00000002);
        run_op("divu8000", 2'b10, 32'h80000000, 32'd1,        5'd6,  32'h80000000);
        run_op("remu8000", 2'b11, 32'h80000000, 32'd1,        5'd7,  32'h00000000);
        run_op("divu0",    2'b10, 32'h12345678, 32'd0,        5'd8,  32'hFFFFFFFF);
        run_op("remu0",    2'b11, 32'h12345678, 32'd0,        5'd9,  32'h12345678);

        // Start isolation: extra start pulses in RUN and DONE, operands changed mid-run.
        bus.op = 2'b00; bus.operand_a = 32'd3; bus.operand_b = 32'd5; bus.dest_reg = 5'd10;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        ndone = 0; done_k = 0; done_res = '0;
        for (int k = 1; k <= 75; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                done_k = k;
                done_res = bus.result;
            end
            if (k == 5) begin bus.operand_a = 32'd9; bus.operand_b = 32'd9; end
            if (k == 9 || k == 32) begin
                bus.start = 1'b1; bus.op = 2'b10;
                bus.operand_a = 32'd1000; bus.operand_b = 32'd10; bus.dest_reg = 5'd20;
            end else begin
                bus.start = 1'b0;
            end
        end
        chk("iso done_count", 64'(ndone), 64'd1);
        chk("iso done_latency", 64'(done_k), 64'd32);
        chk("iso result", 64'(done_res), 64'h0000000F);
        chk("iso result_reg", 64'(bus.result_reg), 64'd10);
        chk("iso idle_busy", 64'(bus.busy), 64'd0);

        // A start after busy dropped is accepted normally.
        run_op("after_iso", 2'b00, 32'd11, 32'd13, 5'd12, 32'd143);

        // Asynchronous reset at iteration 16 of a DIVU.
        bus.op = 2'b10; bus.operand_a = 32'd1000; bus.operand_b = 32'd3; bus.dest_reg = 5'd15;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("pre_rst busy", 64'(bus.busy), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst busy", 64'(bus.busy), 64'd0);
        chk("rst done", 64'(bus.done), 64'd0);
        chk("rst result", 64'(bus.result), 64'd0);
        chk("rst result_reg", 64'(bus.result_reg), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("post_rst done_count", 64'(ndone), 64'd0);
        chk("post_rst busy", 64'(bus.busy), 64'd0);

        run_op("fresh_divu", 2'b10, 32'd1000, 32'd3, 5'd15, 32'd333);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit unsigned multiply/divide unit sitting directly downstream of the register file. It takes the two register read operands and a destination register index, computes over a fixed 32-iteration sequence, and returns a result plus a one-cycle write strobe for the register file write port. The non-pipelined core stalls on `busy` while the unit is running.

## Interface
- `WIDTH`, 32, operand and result width; the iteration count equals `WIDTH`.
- `clk`  input  1  clock; all state changes on the rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request strobe; sampled only in IDLE.
- `op`  input  2  operation select: 00 MUL (low word), 01 MULHU (high word), 10 DIVU (quotient), 11 REMU (remainder).
- `operand_a`  input  WIDTH  rs1 value (register file read port 1).
- `operand_b`  input  WIDTH  rs2 value (register file read port 2).
- `dest_reg`  input  5  destination register index, captured with the operands.
- `busy`  output  1  high whenever the state is not IDLE.
- `done`  output  1  one-cycle completion pulse; also the register file write enable.
- `result`  output  WIDTH  final value; held stable until the next accepted start.
- `result_reg`  output  5  captured `dest_reg`; held with `result`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE with `start`=1 captures `op`, `operand_a`, `operand_b`, `dest_reg`, clears the iteration counter, and moves to RUN. IDLE with `start`=0 stays in IDLE.
- RUN performs one iteration per cycle. The 6-bit counter increments each cycle. After the 32nd iteration the state moves to DONE.
- DONE asserts `done` for exactly one cycle, loads `result` and `result_reg`, then returns to IDLE unconditionally.
- `start` in RUN or DONE is ignored. The request is neither queued nor allowed to corrupt the operation in flight.
- **Multiply:** shift-add over a 2×WIDTH (64-bit) product register.
  - MUL returns product[31:0].
  - MULHU returns product[63:32].
  - All arithmetic is unsigned and modulo 2^64, with no overflow flag.
- **Divide:** restoring division.
  - The partial remainder is WIDTH+1 bits wide to hold the compare/subtract borrow.
  - Each iteration shifts in one dividend bit and subtracts the divisor if remainder ≥ divisor, setting the quotient bit.
- **Divide by zero:** no special path. The natural restoring result is required: DIVU = 0xFFFFFFFF, REMU = `operand_a`. Latency is the same as any other operation.
- Operands are captured internally, so upstream may change `operand_a` and `operand_b` after the start cycle.

## Timing
- Reset (`reset_n`=0, asynchronous) forces the following, regardless of the current state:
  - state = IDLE
  - `busy` = 0, `done` = 0
  - `result` = 0, `result_reg` = 0
  - counter and datapath registers = 0
- Reset during RUN aborts the operation with no `done` pulse. Release of reset takes effect on the next rising edge.
- Edge E0: `start` sampled in IDLE; `busy` goes high after E0.
- Edges E1–E32: the 32 iterations; the state enters DONE after E32.
- Cycle after E32: `done`=1, with `result` and `result_reg` valid. After E33: IDLE, `busy`=0, `done`=0.
- Latency from the accepted start edge to the `done` cycle is 32 cycles. Busy occupancy is 33 cycles. Back-to-back throughput is one operation per 34 cycles (E33 returns to IDLE, E34 may accept the next start).
- `result` and `result_reg` update only in the DONE cycle. They are stable at all other times.
- `done` is never asserted in two consecutive cycles.

## Test plan
- **MUL 7 × 6:** start with a=7, b=6, op=00, dest_reg=5 → `done` exactly 32 cycles after the start edge with `result`=0x0000002A and `result_reg`=5; `busy` high for 33 cycles.
- **0xFFFFFFFF × 0xFFFFFFFF:** MUL → 0x00000001; MULHU → 0xFFFFFFFE.
- **DIVU/REMU 100 / 7:** DIVU → 0x0000000E; REMU → 0x00000002. Also 0x80000000 / 1 → quotient 0x80000000, remainder 0.
- **Divide by zero with a=0x12345678, b=0:** DIVU → 0xFFFFFFFF; REMU → 0x12345678; latency unchanged.
- **Busy and input isolation:** start MUL 3 × 5, pulse `start` with different operands at cycles 10 and 33, and change `operand_a`/`operand_b` mid-run → single `done` with `result`=0x0000000F; no second `done`; a new start accepted only once `busy`=0.
- **Reset mid-operation:** assert `reset_n`=0 asynchronously at iteration 16 of a DIVU → `busy`, `done`, `result` and `result_reg` all 0 immediately; no `done` afterward; a fresh start after release completes normally.
